// File: rtl/sgbm_rst_seq_if.sv
// Signal bundle between the SGBM reset sequencer and its environment.
// The master side drives the PLL lock and the software reset request. The slave
// side (the sequencer) drives the staged resets and the status outputs.
// Optional macro SGBM_RST_LOSS_CNT_EN adds the lock_loss_cnt signal.
interface sgbm_rst_seq_if #(
  parameter int unsigned N_STAGES = 3
);
  logic                pll_locked;
  logic                sw_rst_req;
  logic [N_STAGES-1:0] rst_n_stage;
  logic                ready;
  logic                lock_lost;
`ifdef SGBM_RST_LOSS_CNT_EN
  logic [7:0]          lock_loss_cnt;

  modport master (
    output pll_locked,
    output sw_rst_req,
    input  rst_n_stage,
    input  ready,
    input  lock_lost,
    input  lock_loss_cnt
  );

  modport slave (
    input  pll_locked,
    input  sw_rst_req,
    output rst_n_stage,
    output ready,
    output lock_lost,
    output lock_loss_cnt
  );
`else
  modport master (
    output pll_locked,
    output sw_rst_req,
    input  rst_n_stage,
    input  ready,
    input  lock_lost
  );

  modport slave (
    input  pll_locked,
    input  sw_rst_req,
    output rst_n_stage,
    output ready,
    output lock_lost
  );
`endif
endinterface

// File: rtl/sgbm_rst_seq.sv
// SGBM reset sequencer. Qualifies PLL lock over a stable window, then releases
// the active-low stage resets one at a time (bit 0 first) and raises ready.
// Lock loss or a software request re-asserts every stage reset at once.
// Optional macro SGBM_RST_LOSS_CNT_EN adds a saturating lock-loss counter.
module sgbm_rst_seq #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned STAGE_GAP          = 16,
  parameter int unsigned N_STAGES           = 3,
  parameter int unsigned SW_RST_CYCLES      = 8
) (
  input logic            clk,
  input logic            restn,
  sgbm_rst_seq_if.slave  bus_io
);

  localparam int unsigned RelSpan = N_STAGES * STAGE_GAP;
  localparam int unsigned MaxA    = (LOCK_STABLE_CYCLES > RelSpan) ? LOCK_STABLE_CYCLES : RelSpan;
  localparam int unsigned MaxSpan = (MaxA > SW_RST_CYCLES) ? MaxA : SW_RST_CYCLES;
  localparam int unsigned CntW    = $clog2(MaxSpan) + 1;

  localparam logic [CntW-1:0] LastStable = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] LastGap    = CntW'(STAGE_GAP - 1);
  localparam logic [CntW-1:0] LastSw     = CntW'(SW_RST_CYCLES - 1);
  localparam logic [N_STAGES-1:0] FirstStage = N_STAGES'(1);

  typedef enum logic [2:0] {
    StWaitLock,
    StStable,
    StRelease,
    StRun,
    StSwHold
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [N_STAGES-1:0] stage_q, stage_d;
  logic                ready_q, ready_d;
  logic                lost_q, lost_d;
  logic                sync1_q, locked_s_q;
  logic [N_STAGES:0]   shift_w;

  // Next release pattern: one more low-order stage brought out of reset.
  assign shift_w = {stage_q, 1'b1};

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= bus_io.pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      state_q <= StWaitLock;
      cnt_q   <= '0;
      stage_q <= '0;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
    end
  end

  // Sequencing decisions; lock loss beats the software request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    ready_d = ready_q;
    lost_d  = 1'b0;
    unique case (state_q)
      StWaitLock: begin
        stage_d = '0;
        ready_d = 1'b0;
        if (locked_s_q) begin
          state_d = StStable;
          cnt_d   = '0;
        end
      end
      StStable: begin
        if (!locked_s_q) begin
          // Not yet qualified, so this is not reported as a lock loss.
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == LastStable) begin
          state_d = StRelease;
          cnt_d   = '0;
          stage_d = FirstStage;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        if (!locked_s_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
          stage_d = '0;
          ready_d = 1'b0;
          lost_d  = 1'b1;
        end else if (&stage_q) begin
          state_d = StRun;
          ready_d = 1'b1;
        end else if (cnt_q == LastGap) begin
          cnt_d   = '0;
          stage_d = shift_w[N_STAGES-1:0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!locked_s_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
          stage_d = '0;
          ready_d = 1'b0;
          lost_d  = 1'b1;
        end else if (bus_io.sw_rst_req) begin
          state_d = StSwHold;
          cnt_d   = '0;
          stage_d = '0;
          ready_d = 1'b0;
        end
      end
      StSwHold: begin
        if (!locked_s_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
          stage_d = '0;
          ready_d = 1'b0;
          lost_d  = 1'b1;
        end else if (cnt_q == LastSw) begin
          // Lock never dropped, so the stability window is skipped.
          state_d = StRelease;
          cnt_d   = '0;
          stage_d = FirstStage;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
        stage_d = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign bus_io.rst_n_stage = stage_q;
  assign bus_io.ready       = ready_q;
  assign bus_io.lock_lost   = lost_q;

`ifdef SGBM_RST_LOSS_CNT_EN
  logic [7:0] loss_cnt_q;

  // Saturating count of lock-loss pulses, cleared only by restn.
  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      loss_cnt_q <= '0;
    end else if (lost_d && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign bus_io.lock_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_sgbm_rst_seq.sv
// Bench for sgbm_rst_seq: directed scenarios push the expected output-change
// events (edge number and output values); a monitor pops one whenever the
// outputs change and compares.
module tb_sgbm_rst_seq;

  typedef struct packed {
    logic [31:0] edge_n;
    logic [2:0]  stage;
    logic        rdy;
    logic        lost;
  } ev_t;

  logic        clk;
  logic        restn;
  int unsigned edge_n;
  int unsigned n_vec;
  int unsigned n_err;
  bit          mon_en;
  ev_t         exp_q[$];
  int unsigned b;

  sgbm_rst_seq_if #(.N_STAGES(3)) bus_if ();

  sgbm_rst_seq #(
    .LOCK_STABLE_CYCLES(8),
    .STAGE_GAP         (4),
    .N_STAGES          (3),
    .SW_RST_CYCLES     (8)
  ) dut (
    .clk   (clk),
    .restn (restn),
    .bus_io(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int unsigned e, input logic [2:0] s, input logic r, input logic l);
    ev_t ev;
    ev.edge_n = e;
    ev.stage  = s;
    ev.rdy    = r;
    ev.lost   = l;
    exp_q.push_back(ev);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Expected full clean-lock release sequence relative to lock edge e0.
  task automatic push_clean(input int unsigned e0);
    push(e0 + 11, 3'b001, 1'b0, 1'b0);
    push(e0 + 15, 3'b011, 1'b0, 1'b0);
    push(e0 + 19, 3'b111, 1'b0, 1'b0);
    push(e0 + 20, 3'b111, 1'b1, 1'b0);
  endtask

  // Monitor: every observed output change must match the next expected event.
  initial begin
    logic [2:0] p_stage;
    logic       p_rdy;
    logic       p_lost;
    ev_t        a;
    ev_t        e;
    p_stage = 3'b000;
    p_rdy   = 1'b0;
    p_lost  = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) continue;
      if (bus_if.rst_n_stage !== p_stage || bus_if.ready !== p_rdy ||
          bus_if.lock_lost !== p_lost) begin
        a.edge_n = edge_n;
        a.stage  = bus_if.rst_n_stage;
        a.rdy    = bus_if.ready;
        a.lost   = bus_if.lock_lost;
        p_stage  = bus_if.rst_n_stage;
        p_rdy    = bus_if.ready;
        p_lost   = bus_if.lock_lost;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_change edge=%0d got stage=%b ready=%b lost=%b",
                   a.edge_n, a.stage, a.rdy, a.lost);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            n_err++;
            $display("FAIL out_event got edge=%0d stage=%b ready=%b lost=%b want edge=%0d stage=%b ready=%b lost=%b",
                     a.edge_n, a.stage, a.rdy, a.lost, e.edge_n, e.stage, e.rdy, e.lost);
          end
        end
      end
    end
  end

  initial begin
    ev_t e;
    n_vec = 0;
    n_err = 0;
    mon_en = 1'b0;
    restn = 1'b0;
    bus_if.pll_locked = 1'b0;
    bus_if.sw_rst_req = 1'b0;
    wait_edges(2);

    chk("reset_stage", 32'(bus_if.rst_n_stage), 32'd0);
    chk("reset_ready", 32'(bus_if.ready), 32'd0);
    chk("reset_lost", 32'(bus_if.lock_lost), 32'd0);
`ifdef SGBM_RST_LOSS_CNT_EN
    chk("reset_cnt", 32'(bus_if.lock_loss_cnt), 32'd0);
`endif
    mon_en = 1'b1;
    restn = 1'b1;
    wait_edges(2);

    // Clean lock.
    b = edge_n;
    bus_if.pll_locked = 1'b1;
    push_clean(b);
    wait_edges(25);

    // Software reset sampled at edge b+1.
    b = edge_n + 1;
    bus_if.sw_rst_req = 1'b1;
    push(b,      3'b000, 1'b0, 1'b0);
    push(b + 8,  3'b001, 1'b0, 1'b0);
    push(b + 12, 3'b011, 1'b0, 1'b0);
    push(b + 16, 3'b111, 1'b0, 1'b0);
    push(b + 17, 3'b111, 1'b1, 1'b0);
    wait_edges(1);
    bus_if.sw_rst_req = 1'b0;
    wait_edges(22);

    // Lock loss in RUN, then relock.
    b = edge_n;
    bus_if.pll_locked = 1'b0;
    push(b + 3, 3'b000, 1'b0, 1'b1);
    push(b + 4, 3'b000, 1'b0, 1'b0);
    wait_edges(4);
`ifdef SGBM_RST_LOSS_CNT_EN
    chk("loss_cnt_1", 32'(bus_if.lock_loss_cnt), 32'd1);
`endif
    wait_edges(2);
    b = edge_n;
    bus_if.pll_locked = 1'b1;
    push_clean(b);
    wait_edges(25);

    // Lock loss and software request on the same edge: lock loss wins.
    b = edge_n;
    bus_if.pll_locked = 1'b0;
    wait_edges(2);
    bus_if.sw_rst_req = 1'b1;
    push(b + 3, 3'b000, 1'b0, 1'b1);
    push(b + 4, 3'b000, 1'b0, 1'b0);
    wait_edges(1);
    bus_if.sw_rst_req = 1'b0;
    wait_edges(3);
`ifdef SGBM_RST_LOSS_CNT_EN
    chk("loss_cnt_2", 32'(bus_if.lock_loss_cnt), 32'd2);
`endif

    // Two-cycle lock glitch during STABLE restarts qualification.
    wait_edges(2);
    b = edge_n;
    bus_if.pll_locked = 1'b1;
    push(b + 18, 3'b001, 1'b0, 1'b0);
    push(b + 22, 3'b011, 1'b0, 1'b0);
    push(b + 26, 3'b111, 1'b0, 1'b0);
    push(b + 27, 3'b111, 1'b1, 1'b0);
    wait_edges(5);
    bus_if.pll_locked = 1'b0;
    wait_edges(2);
    bus_if.pll_locked = 1'b1;
    wait_edges(25);

    // Async reset out of RUN, then async reset at edge 16 of a clean-lock run.
    b = edge_n;
    push(b, 3'b000, 1'b0, 1'b0);
    restn = 1'b0;
    bus_if.pll_locked = 1'b0;
    wait_edges(2);
    restn = 1'b1;
    wait_edges(2);
    b = edge_n;
    bus_if.pll_locked = 1'b1;
    push(b + 11, 3'b001, 1'b0, 1'b0);
    push(b + 15, 3'b011, 1'b0, 1'b0);
    push(b + 16, 3'b000, 1'b0, 1'b0);
    wait_edges(16);
    restn = 1'b0;
    #1;
    chk("async_stage", 32'(bus_if.rst_n_stage), 32'd0);
    chk("async_ready", 32'(bus_if.ready), 32'd0);
    chk("async_lost", 32'(bus_if.lock_lost), 32'd0);
`ifdef SGBM_RST_LOSS_CNT_EN
    chk("async_cnt", 32'(bus_if.lock_loss_cnt), 32'd0);
`endif
    wait_edges(2);
    b = edge_n;
    push_clean(b);
    restn = 1'b1;
    wait_edges(26);

    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_event got none want edge=%0d stage=%b ready=%b lost=%b",
               e.edge_n, e.stage, e.rdy, e.lost);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sgbm_rst_seq.md
# sgbm_rst_seq

Reset sequencer on the consuming side of the SGBM PLL. It takes the PLL output clock and the PLL lock indication and qualifies lock over a stable window. It then releases staged active-low resets to the SGBM pipeline stages in order and raises `ready`. On lock loss or a software reset request it re-asserts all stage resets and repeats the sequence.

## Interface
Parameters:
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release; ≥1.
- `STAGE_GAP`, 16: cycles between successive stage releases; ≥1.
- `N_STAGES`, 3: number of staged reset outputs; 1..8.
- `SW_RST_CYCLES`, 8: hold time of a software-requested reset; ≥1.

Ports:
- `clk`  in  1  PLL output clock; only clock.
- `restn`  in  1  asynchronous, active-low reset.
- `pll_locked`  in  1  PLL lock; asynchronous to `clk`.
- `sw_rst_req`  in  1  single-cycle request, synchronous to `clk`.
- `rst_n_stage`  out  N_STAGES  active-low stage resets; bit 0 released first.
- `ready`  out  1  all stages out of reset.
- `lock_lost`  out  1  one-cycle pulse on lock loss after qualification.
- `lock_loss_cnt`  out  8  saturating lock-loss count (only with `SGBM_RST_LOSS_CNT_EN`).

## Operation
- `pll_locked` passes through a 2-flop synchronizer to `locked_s`. Both flops reset to 0.
- All outputs are registered. On `restn`=0, asynchronously: `rst_n_stage`=0, `ready`=0, `lock_lost`=0, `lock_loss_cnt`=0, counter=0, state=WAIT_LOCK.
- Counter width: $clog2 of the largest of `LOCK_STABLE_CYCLES`, `N_STAGES*STAGE_GAP`, `SW_RST_CYCLES`, plus 1.
- FSM states and transitions:
  - WAIT_LOCK: all stage resets asserted. Go to STABLE when `locked_s`=1, with counter=0.
  - STABLE: counter increments each cycle. If `locked_s`=0, return to WAIT_LOCK; no `lock_lost` pulse. When counter=`LOCK_STABLE_CYCLES`-1, go to RELEASE. STABLE lasts exactly `LOCK_STABLE_CYCLES` cycles.
  - RELEASE: `rst_n_stage[0]` goes 1 on the entry edge. `rst_n_stage[k]` goes 1 exactly `k*STAGE_GAP` edges later. On the edge after the last stage releases, go to RUN and set `ready`=1.
  - RUN: hold. A `locked_s`=0 sample, or `sw_rst_req`=1 on the same edge, causes an exit.
  - SW_HOLD: all stage resets 0 and `ready`=0 for `SW_RST_CYCLES` cycles. Then go to RELEASE if `locked_s`=1, else WAIT_LOCK. The stability wait is skipped.
- Lock loss (`locked_s`=0) in RELEASE, RUN or SW_HOLD, on the next edge:
  - all `rst_n_stage`=0 and `ready`=0;
  - `lock_lost`=1 for one cycle;
  - state=WAIT_LOCK.
- Priority: lock loss overrides `sw_rst_req` on the same edge. `sw_rst_req` is ignored outside RUN.
- Stage resets never release out of order. Any reassertion is simultaneous on all bits.

## Timing
- Lock synchronization: 2 cycles.
- Lock to first release: from the first edge `pll_locked` is sampled high, `rst_n_stage[0]` rises at edge `LOCK_STABLE_CYCLES`+3.
- `ready` rises at edge `LOCK_STABLE_CYCLES`+3+(`N_STAGES`-1)*`STAGE_GAP`+1.
- Lock loss response: `pll_locked` falling to resets asserted is 3 edges (2 sync + 1 register).
- Software reset: `sw_rst_req` sampled at edge s gives resets asserted after s. `rst_n_stage[0]` rises at s+`SW_RST_CYCLES`.
- Async reset mid-sequence takes effect immediately. After `restn` deasserts, the full sequence restarts from WAIT_LOCK.

## Configuration
- `SGBM_RST_LOSS_CNT_EN` defined:
  - `lock_loss_cnt` port exists;
  - it increments on every `lock_lost` pulse and saturates at 255;
  - it is cleared only by `restn`.
- Undefined: port and counter are absent; all other behaviour is identical.

## Test plan
Parameters for all scenarios: LOCK_STABLE_CYCLES=8, STAGE_GAP=4, N_STAGES=3, SW_RST_CYCLES=8.
- Clean lock: `pll_locked` high from edge 0 -> `rst_n_stage` goes 3'b001 at edge 11, 3'b011 at 15, 3'b111 at 19; `ready`=1 at 20; `lock_lost` never pulses.
- Lock glitch: `pll_locked` low for 2 cycles while in STABLE -> stability count restarts; first release is delayed by the glitch plus 8 cycles; `lock_lost`=0.
- Lock loss in RUN: `pll_locked` falls before edge k -> `rst_n_stage`=0, `ready`=0 and `lock_lost`=1 for one cycle at edge k+2; with the macro, `lock_loss_cnt`=1; relock repeats the clean-lock timing.
- Software reset: `sw_rst_req` pulse at edge s in RUN -> resets 0 after s; stage0 released at s+8, stage1 at s+12, stage2 at s+16; `ready` at s+17.
- Simultaneous events: `sw_rst_req`=1 on the same edge `locked_s` first samples 0 -> lock-loss path taken, `lock_lost`=1, state WAIT_LOCK.
- Async reset at edge 16 of the clean-lock run -> all outputs 0 immediately; after release, the full 20-edge sequence repeats.
